// File: rtl/mul32_seq_ctrl_if.sv
// rtl/mul32_seq_ctrl_if.sv - operand, result and shared-multiplier bus for mul32_seq_ctrl
interface mul32_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;

  // master: operand source, result consumer and the wallace16 instance
  modport master (
    output in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_p
  );
endinterface

// File: rtl/mul32_seq_ctrl.sv
// rtl/mul32_seq_ctrl.sv - 32x32->64 unsigned multiply sequenced over one shared 16x16 multiplier
// Optional zero-half step skipping enabled by defining MUL32_SEQ_ZSKIP_EN.
module mul32_seq_ctrl (
  input  logic             clk_i,
  input  logic             rst_i,
  mul32_seq_ctrl_if.slave  bus,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e      state_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q;
  logic [3:0]  mask_q;
  logic [1:0]  step_q;
  logic        in_ready_q, out_valid_q, busy_q;
  logic [15:0] mul_a_q, mul_b_q;

  logic [3:0]  mask_d, rem_mask;
  logic [2:0]  first_d, next_d;
  logic [15:0] first_a_d, first_b_d, next_a_d, next_b_d;
  logic [63:0] acc_d;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [2:0] pick_step(input logic [3:0] m);
    pick_step = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i]) pick_step = {1'b1, 2'(i)};
  endfunction

  // Step k uses a half k[0] and b half k[1].
  function automatic logic [31:0] halves(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] k);
    halves = {k[0] ? a[31:16] : a[15:0], k[1] ? b[31:16] : b[15:0]};
  endfunction

  always_comb begin
`ifdef MUL32_SEQ_ZSKIP_EN
    mask_d = {(|bus.in_a[31:16]) && (|bus.in_b[31:16]),
              (|bus.in_a[15:0])  && (|bus.in_b[31:16]),
              (|bus.in_a[31:16]) && (|bus.in_b[15:0]),
              (|bus.in_a[15:0])  && (|bus.in_b[15:0])};
`else
    mask_d = 4'b1111;
`endif
    rem_mask               = mask_q & (4'b1110 << step_q);
    first_d                = pick_step(mask_d);
    next_d                 = pick_step(rem_mask);
    {first_a_d, first_b_d} = halves(bus.in_a, bus.in_b, first_d[1:0]);
    {next_a_d, next_b_d}   = halves(a_q, b_q, next_d[1:0]);
    case (step_q)
      2'd0:    acc_d = acc_q + {32'b0, bus.mul_p};
      2'd3:    acc_d = acc_q + {bus.mul_p, 32'b0};
      default: acc_d = acc_q + {16'b0, bus.mul_p, 16'b0};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            acc_q      <= '0;
            mask_q     <= mask_d;
            in_ready_q <= 1'b0;
            if (first_d[2]) begin
              state_q <= MUL;
              step_q  <= first_d[1:0];
              busy_q  <= 1'b1;
              mul_a_q <= first_a_d;
              mul_b_q <= first_b_d;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q <= acc_d;
          if (next_d[2]) begin
            step_q  <= next_d[1:0];
            mul_a_q <= next_a_d;
            mul_b_q <= next_b_d;
          end else begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          mul_a_q     <= '0;
          mul_b_q     <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = acc_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign busy_o        = busy_q;

endmodule
